// File: rtl/alu_bist.sv
// Built-in self-test initiator for the combinational ALU: LFSR operand pairs swept over all
// ten op codes, responses compacted into a 32-bit MISR. Optional corner phase: ALU_BIST_CORNER_EN.
module alu_bist #(
   parameter int          N_VECTORS    = 256,
   parameter logic [31:0] SEED_A       = 32'h0000_0001,
   parameter logic [31:0] SEED_B       = 32'h0000_0002,
   parameter logic [31:0] EXPECTED_SIG = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [31:0] alu_data_i,
   output logic [31:0] operand_a_o,
   output logic [31:0] operand_b_o,
   output logic [3:0]  alu_op_o,
   output logic        bist_active_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        pass_o,
   output logic [31:0] signature_o
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_INIT = 2'd1;
   localparam logic [1:0] S_RUN  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

`ifdef ALU_BIST_CORNER_EN
   localparam int N_CORNER = 4;
`else
   localparam int N_CORNER = 0;
`endif
   localparam logic [31:0] LAST_VEC  = 32'(N_VECTORS + N_CORNER - 1);
   localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
   localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;
   localparam logic [3:0]  LAST_OP   = 4'd9;

   function automatic logic [31:0] lfsr_step(input logic [31:0] v);
      return (v >> 1) ^ (v[0] ? LFSR_POLY : 32'h0);
   endfunction

   function automatic logic [31:0] misr_step(input logic [31:0] sig, input logic [31:0] din);
      return (sig << 1) ^ (sig[31] ? MISR_POLY : 32'h0) ^ din;
   endfunction

   // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
   function automatic logic [31:0] seed_fix(input logic [31:0] s);
      return (s == 32'h0) ? 32'h1 : s;
   endfunction

   logic [1:0]  state_q, state_d;
   logic [31:0] lfsr_a_q, lfsr_a_d, lfsr_b_q, lfsr_b_d;
   logic [31:0] misr_q, misr_d;
   logic [3:0]  op_q, op_d;
   logic [31:0] vec_q, vec_d;
   logic        pass_q, pass_d;
   logic [31:0] opa_q, opa_d, opb_q, opb_d;
   logic [3:0]  aluop_q, aluop_d;
   logic        bist_q, bist_d, busy_q, busy_d, done_q, done_d;
   logic        lfsr_step_en;
   logic [31:0] stim_a, stim_b;

   always_comb begin
      state_d  = state_q;
      lfsr_a_d = lfsr_a_q;
      lfsr_b_d = lfsr_b_q;
      misr_d   = misr_q;
      op_d     = op_q;
      vec_d    = vec_q;
      pass_d   = pass_q;
`ifdef ALU_BIST_CORNER_EN
      lfsr_step_en = (vec_q >= 32'd4);
`else
      lfsr_step_en = 1'b1;
`endif
      case (state_q)
         S_IDLE: begin
            if (start_i) state_d = S_INIT;
         end
         S_INIT: begin
            lfsr_a_d = seed_fix(SEED_A);
            lfsr_b_d = seed_fix(SEED_B);
            misr_d   = 32'h0;
            op_d     = 4'd0;
            vec_d    = 32'h0;
            pass_d   = 1'b0;
            state_d  = S_RUN;
         end
         S_RUN: begin
            misr_d = misr_step(misr_q, alu_data_i);
            if (op_q == LAST_OP) begin
               op_d  = 4'd0;
               vec_d = vec_q + 32'd1;
               if (lfsr_step_en) begin
                  lfsr_a_d = lfsr_step(lfsr_a_q);
                  lfsr_b_d = lfsr_step(lfsr_b_q);
               end
               if (vec_q == LAST_VEC) begin
                  state_d = S_DONE;
                  pass_d  = (misr_d == EXPECTED_SIG);
               end
            end else begin
               op_d = op_q + 4'd1;
            end
         end
         default: begin
            if (start_i) begin
               state_d = S_INIT;
               pass_d  = 1'b0;
            end
         end
      endcase
   end

   // Outputs are registered from next-state values so they line up with the state they describe.
   always_comb begin
      stim_a = lfsr_a_d;
      stim_b = lfsr_b_d;
`ifdef ALU_BIST_CORNER_EN
      case (vec_d)
         32'd0:   begin stim_a = 32'h0000_0000; stim_b = 32'h0000_0000; end
         32'd1:   begin stim_a = 32'hFFFF_FFFF; stim_b = 32'h0000_0001; end
         32'd2:   begin stim_a = 32'h8000_0000; stim_b = 32'h0000_001F; end
         32'd3:   begin stim_a = 32'h7FFF_FFFF; stim_b = 32'hFFFF_FFFF; end
         default: ;
      endcase
`endif
      bist_d  = (state_d == S_RUN);
      busy_d  = (state_d == S_INIT) || (state_d == S_RUN);
      done_d  = (state_d == S_DONE);
      opa_d   = bist_d ? stim_a : 32'h0;
      opb_d   = bist_d ? stim_b : 32'h0;
      aluop_d = bist_d ? op_d : 4'd0;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         lfsr_a_q <= 32'h0;
         lfsr_b_q <= 32'h0;
         misr_q   <= 32'h0;
         op_q     <= 4'd0;
         vec_q    <= 32'h0;
         pass_q   <= 1'b0;
         opa_q    <= 32'h0;
         opb_q    <= 32'h0;
         aluop_q  <= 4'd0;
         bist_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         lfsr_a_q <= lfsr_a_d;
         lfsr_b_q <= lfsr_b_d;
         misr_q   <= misr_d;
         op_q     <= op_d;
         vec_q    <= vec_d;
         pass_q   <= pass_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         aluop_q  <= aluop_d;
         bist_q   <= bist_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign operand_a_o   = opa_q;
   assign operand_b_o   = opb_q;
   assign alu_op_o      = aluop_q;
   assign bist_active_o = bist_q;
   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign pass_o        = pass_q;
   assign signature_o   = misr_q;

endmodule

// File: doc/alu_bist.md
Name: alu_bist

Overview:
- Built-in self-test initiator for the single-cycle core's combinational ALU.
- It drives the ALU's operand A, operand B and op-code inputs, and consumes the ALU result.
- Stimulus: pseudo-random operand pairs from two LFSRs, each swept across all ten ALU op codes.
- Responses are compacted into a 32-bit MISR and compared against an expected signature at the end of the run.
- It sits beside the ALU; bist_active_o steers the datapath operand/op muxes to this block during test.

Parameters:
N_VECTORS, 256, number of LFSR operand pairs applied (≥1); each pair is applied for 10 cycles
SEED_A, 32'h0000_0001, LFSR A seed; a value of 0 is replaced by 1
SEED_B, 32'h0000_0002, LFSR B seed; a value of 0 is replaced by 1
EXPECTED_SIG, 32'h0000_0000, golden MISR signature for a fault-free ALU

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-high reset
start_i  in  1  start request; sampled in IDLE and DONE only
alu_data_i  in  32  ALU result (combinational from the ALU, same cycle)
operand_a_o  out  32  ALU operand A
operand_b_o  out  32  ALU operand B
alu_op_o  out  4  ALU op code, using the codebase encoding 0=add 1=sll 2=slt 3=sltu 4=xor 5=srl 6=sra 7=or 8=and 9=sub
bist_active_o  out  1  high while RUN; selects BIST stimulus into the ALU
busy_o  out  1  high in INIT and RUN
done_o  out  1  high in DONE (level)
pass_o  out  1  signature == EXPECTED_SIG; valid only while done_o=1
signature_o  out  32  current MISR contents

Behaviour:
- Reset (async): state=IDLE; all outputs 0; LFSRs, MISR, op counter and vector counter cleared. This applies equally to reset asserted mid-run: the block returns to IDLE immediately and no partial result is reported.
- All outputs are registered. Stimulus outputs are 0 whenever the state is not RUN.
- FSM states: IDLE, INIT, RUN, DONE.
  - IDLE: start_i=1 → INIT.
  - INIT (1 cycle): LFSR A←SEED_A, LFSR B←SEED_B (0 replaced by 1); MISR←0; op counter←0; vector counter←0. Next state is RUN.
  - RUN: operand_a_o = LFSR A, operand_b_o = LFSR B, alu_op_o = op counter.
  - DONE: done_o=1 and pass_o is valid. start_i=1 → INIT (restart); otherwise hold.
- Per-cycle work in RUN, at each rising edge:
  - MISR update: sig ← (sig<<1) ^ (sig[31] ? 32'h04C1_1DB7 : 0) ^ alu_data_i.
  - Op counter increments 0→9.
  - On op counter = 9: counter wraps to 0; both LFSRs step (Galois) lfsr ← (lfsr>>1) ^ (lfsr[0] ? 32'h8020_0003 : 0); vector counter increments.
  - When the vector counter reaches N_VECTORS with op = 9, the final MISR update is taken and the next state is DONE.
- Latency: busy_o is high for exactly 1 + 10·N_VECTORS cycles after start_i is sampled. done_o rises the cycle after the last MISR update.
- start_i asserted while busy is ignored. No abort mechanism exists; reset is the only way to stop a run.
- pass_o is registered on entry to DONE as (MISR_final == EXPECTED_SIG). signature_o continuously shows the MISR and holds in DONE.
- alu_data_i is only sampled in RUN; its value in any other state is don't-care.

Optional Feature:
ALU_BIST_CORNER_EN:
- Defined: 4 fixed corner pairs are applied before the LFSR pairs, each swept over all 10 ops:
  - (32'h0, 32'h0)
  - (32'hFFFF_FFFF, 32'h1)
  - (32'h8000_0000, 32'h1F)
  - (32'h7FFF_FFFF, 32'hFFFF_FFFF)
- LFSRs do not step during the corner phase. busy duration becomes 1 + 10·(N_VECTORS+4), and EXPECTED_SIG must include the corner responses.
- Undefined: no corner phase; behaviour exactly as specified above.

Test Plan:
1. Assert rst_i mid-RUN → same cycle all outputs 0, state IDLE. A new start_i then runs to completion normally.
2. N_VECTORS=1, SEED_A=1, SEED_B=2, behavioural ALU connected:
   - RUN cycles present (1,2) with ops 0..9.
   - ALU results 3,4,1,1,3,0,0,3,0,FFFF_FFFF.
   - signature_o = FFFF_FD53; busy_o high 11 cycles.
3. Same as 2 with EXPECTED_SIG=FFFF_FD53 → done_o=1, pass_o=1. Force alu_data_i[0] stuck-at-0 → signature FFFF_FFB6, pass_o=0.
4. N_VECTORS=2, SEED_A=1, SEED_B=2 → second pair presented is (8020_0003, 0000_0001) starting at RUN cycle 11. SEED_A=0 → first operand_a_o = 1.
5. start_i pulsed during RUN → ignored, busy length unchanged. start_i in DONE → INIT, MISR cleared, and the identical signature is reproduced.
6. With ALU_BIST_CORNER_EN, N_VECTORS=1:
   - First RUN cycle presents (0,0, op 0).
   - Pair (8000_0000, 1F) with op 6 yields FFFF_FFFF from the ALU.
   - busy_o is high 51 cycles.
